multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencing controller for the RV32I core datapath (register file, PC register, instruction register, decoder, ALU). It steps each instruction through fetch, decode, execute, memory and writeback states. It drives the enables and mux selects of the datapath, and runs ready/request handshakes with instruction and data memory. A stalled bus times out into a sticky trap; EBREAK halts the core.

## Interface
- TIMEOUT, default 255: max wait cycles per memory handshake before trap (1..255).
- CNT_W, default 8: width of the wait counter; must hold TIMEOUT.

- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  7  opcode field of the current instruction register.
- funct3  in  3  funct3 field of the current instruction register.
- branch_taken  in  1  ALU compare result for the current BRANCH.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_en  out  1  load instruction register.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data access is a store.
- pc_en  out  1  PC register write enable.
- pc_sel  out  2  0 = pc+4, 1 = pc+imm (branch/JAL), 2 = ALU result (JALR).
- alu_a_sel  out  1  0 = rs1, 1 = pc.
- alu_b_sel  out  1  0 = rs2, 1 = imm.
- rf_wen  out  1  register file write enable.
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = pc+4.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  sticky; EBREAK executed.
- trap  out  1  sticky; illegal opcode or handshake timeout.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
- Instruction classes:
  - OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111.
  - JAL 1101111, JALR 1100111, BRANCH 1100011.
  - LOAD 0000011, STORE 0100011, SYSTEM 1110011.
  - Any other opcode is illegal.
- The class is registered on the DECODE edge and held through EXEC/MEM/WB.
- FETCH:
  - imem_req=1.
  - When imem_ready=1: ir_en=1 in the same cycle, next state DECODE.
- DECODE:
  - Illegal opcode → TRAP.
  - SYSTEM with funct3=0 → HALT.
  - SYSTEM with funct3≠0 → TRAP.
  - Otherwise → EXEC.
- EXEC:
  - alu_a_sel=1 for AUIPC/JAL/BRANCH; alu_b_sel=1 for all classes except OP and BRANCH.
  - BRANCH: pc_en=1, pc_sel = branch_taken ? 1 : 0, retire=1, → FETCH.
  - LOAD/STORE → MEM.
  - All other classes → WB.
- MEM:
  - dmem_req=1; dmem_we=1 only for STORE.
  - On dmem_ready, STORE: pc_en=1, pc_sel=0, retire=1, → FETCH.
  - On dmem_ready, LOAD: → WB.
- WB:
  - rf_wen=1, pc_en=1, retire=1, → FETCH.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, else 0.
  - pc_sel: 1 for JAL, 2 for JALR, else 0.
- ALU selects stay valid through MEM and WB. Outputs not listed for a state are 0.
- Timeout:
  - Wait counter clears on entry to FETCH/MEM.
  - It increments on each cycle that a request is high with ready low.
  - When the counter equals TIMEOUT with ready still low → TRAP; the request drops the next cycle.
  - A ready arriving in the same cycle that the count hits TIMEOUT is accepted, with no trap.
- HALT and TRAP are absorbing until reset. In them, all request and enable outputs are 0 and halted/trap respectively is 1.

## Timing
- Reset:
  - rst low forces FETCH, clears the class register, counter, halted and trap.
  - All outputs read 0 while rst is low. imem_req is gated by rst.
  - First imem_req=1 appears in the first cycle after rst deasserts.
- Reset mid-operation abandons the instruction: no retire, no rf_wen, no pc_en.
- Cycles per instruction with zero-wait memory (ready high in the first request cycle):
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR: 4.
  - LOAD: 5.
  - STORE: 4.
  - BRANCH: 3.
- Each wait cycle adds 1.
- Handshakes:
  - A request stays high until ready is sampled or timeout occurs.
  - Ready while no request is pending is ignored.
- Write/update rules:
  - retire coincides exactly with the instruction's pc_en cycle.
  - rf_wen is never high in the same cycle as dmem_req.

## Test plan
- ADDI (0010011), ready always 1 → imem_req@1, ir_en@1, rf_wen+pc_en+retire@4 with wb_sel=0, pc_sel=0, alu_b_sel=1; next fetch @5.
- LW with dmem_ready delayed 3 cycles → dmem_req high 4 cycles, dmem_we=0, then WB with wb_sel=1; retire at cycle 8.
- BEQ with branch_taken=1, then a second BEQ with branch_taken=0 → pc_sel=1 then 0, retire each at cycle 3 of its instruction; rf_wen never asserted.
- JALR → WB with wb_sel=2, pc_sel=2, alu_a_sel=0, alu_b_sel=1.
- imem_ready held 0 with TIMEOUT=4 → trap=1 after 5 request cycles, imem_req drops; the same run with ready arriving on the 5th cycle → no trap.
- Opcode 1111111 → trap; EBREAK (1110011, funct3=0) → halted; rst pulse mid-MEM → state FETCH, halted/trap clear, no retire.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller for an RV32I datapath.
// The FSM walks through FETCH/DECODE/EXEC/MEM/WB. Memory waits are bounded and end in a sticky trap.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_en,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       pc_en,
  output logic [1:0] pc_sel,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       rf_wen,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       halted,
  output logic       trap
);

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StMem, StWb, StHalt, StTrap
  } state_e;

  typedef enum logic [3:0] {
    ClsNone, ClsOp, ClsOpImm, ClsLui, ClsAuipc, ClsJal, ClsJalr,
    ClsBranch, ClsLoad, ClsStore, ClsSystem, ClsIllegal
  } cls_e;

  state_e             state_q, state_d;
  cls_e               cls_q, cls_d, cls_dec;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cnt_expired;

  assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    case (opcode)
      7'b0110011: cls_dec = ClsOp;
      7'b0010011: cls_dec = ClsOpImm;
      7'b0110111: cls_dec = ClsLui;
      7'b0010111: cls_dec = ClsAuipc;
      7'b1101111: cls_dec = ClsJal;
      7'b1100111: cls_dec = ClsJalr;
      7'b1100011: cls_dec = ClsBranch;
      7'b0000011: cls_dec = ClsLoad;
      7'b0100011: cls_dec = ClsStore;
      7'b1110011: cls_dec = ClsSystem;
      default:    cls_dec = ClsIllegal;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    cnt_d     = '0;
    imem_req  = 1'b0;
    ir_en     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = 2'd0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    rf_wen    = 1'b0;
    wb_sel    = 2'd0;
    retire    = 1'b0;
    halted    = 1'b0;
    trap      = 1'b0;

    // ALU selects are held from EXEC through MEM and WB.
    if (state_q == StExec || state_q == StMem || state_q == StWb) begin
      alu_a_sel = (cls_q == ClsAuipc) || (cls_q == ClsJal) || (cls_q == ClsBranch);
      alu_b_sel = !((cls_q == ClsOp) || (cls_q == ClsBranch));
    end

    unique case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_en   = 1'b1;
          state_d = StDecode;
        end else if (cnt_expired) begin
          state_d = StTrap;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDecode: begin
        cls_d = cls_dec;
        if (cls_dec == ClsIllegal)     state_d = StTrap;
        else if (cls_dec == ClsSystem) state_d = (funct3 == 3'd0) ? StHalt : StTrap;
        else                           state_d = StExec;
      end
      StExec: begin
        if (cls_q == ClsBranch) begin
          pc_en   = 1'b1;
          pc_sel  = branch_taken ? 2'd1 : 2'd0;
          retire  = 1'b1;
          state_d = StFetch;
        end else if (cls_q == ClsLoad || cls_q == ClsStore) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == ClsStore);
        if (dmem_ready) begin
          if (cls_q == ClsStore) begin
            pc_en   = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (cnt_expired) begin
          state_d = StTrap;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StWb: begin
        rf_wen  = 1'b1;
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
        if (cls_q == ClsLoad)                         wb_sel = 2'd1;
        else if (cls_q == ClsJal || cls_q == ClsJalr) wb_sel = 2'd2;
        if (cls_q == ClsJal)       pc_sel = 2'd1;
        else if (cls_q == ClsJalr) pc_sel = 2'd2;
      end
      StHalt: halted = 1'b1;
      StTrap: trap   = 1'b1;
      default: state_d = StTrap;
    endcase

    // Outputs are forced quiet for as long as reset is asserted.
    if (!rst) begin
      imem_req  = 1'b0;
      ir_en     = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      pc_en     = 1'b0;
      pc_sel    = 2'd0;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      rf_wen    = 1'b0;
      wb_sel    = 2'd0;
      retire    = 1'b0;
      halted    = 1'b0;
      trap      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFetch;
      cls_q   <= ClsNone;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output vectors go through a scoreboard queue.
module tb_multicycle_ctrl;

  logic       clk, rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       branch_taken, imem_ready, dmem_ready;
  logic       imem_req, ir_en, dmem_req, dmem_we, pc_en, alu_a_sel, alu_b_sel;
  logic       rf_wen, retire, halted, trap;
  logic [1:0] pc_sel, wb_sel;

  multicycle_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_en(ir_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .pc_en(pc_en), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .rf_wen(rf_wen), .wb_sel(wb_sel), .retire(retire), .halted(halted), .trap(trap)
  );

  // Output vector: {imem_req, ir_en, dmem_req, dmem_we, pc_en, pc_sel, alu_a, alu_b,
  //                 rf_wen, wb_sel, retire, halted, trap}
  localparam logic [14:0] IREQ = 15'h4000, IREN = 15'h2000, DREQ = 15'h1000;
  localparam logic [14:0] DWE  = 15'h0800, PCEN = 15'h0400, PCS1 = 15'h0100;
  localparam logic [14:0] PCS2 = 15'h0200, ALA  = 15'h0080, ALB  = 15'h0040;
  localparam logic [14:0] RFW  = 15'h0020, WB2  = 15'h0010, WB1  = 15'h0008;
  localparam logic [14:0] RET  = 15'h0004, HLT  = 15'h0002, TRP  = 15'h0001;
  localparam logic [14:0] NONE = 15'h0000;
  localparam logic [14:0] FET  = IREQ | IREN;

  logic [14:0] exp_q[$];
  string       tag_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic rv, input logic ir, input logic dr, input logic br,
                      input logic [14:0] e, input string tag);
    logic [14:0] obs, want;
    string       t;
    rst = rv; imem_ready = ir; dmem_ready = dr; branch_taken = br;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    obs  = {imem_req, ir_en, dmem_req, dmem_we, pc_en, pc_sel, alu_a_sel, alu_b_sel,
            rf_wen, wb_sel, retire, halted, trap};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", t, obs, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_insn(input logic [6:0] op, input logic [2:0] f3);
    opcode = op;
    funct3 = f3;
  endtask

  initial begin
    rst = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b0;
    set_insn(7'b0010011, 3'd0);
    @(posedge clk); #1;
    step(0, 1, 1, 1, NONE, "reset_quiet");

    // ADDI, zero-wait
    step(1, 1, 1, 0, FET, "addi_fetch");
    step(1, 1, 1, 0, NONE, "addi_decode");
    step(1, 1, 1, 0, ALB, "addi_exec");
    step(1, 1, 1, 0, RFW | PCEN | RET | ALB, "addi_wb");

    // LW with three dmem wait cycles
    set_insn(7'b0000011, 3'd2);
    step(1, 1, 0, 0, FET, "lw_fetch");
    step(1, 1, 0, 0, NONE, "lw_decode");
    step(1, 1, 0, 0, ALB, "lw_exec");
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, DREQ | ALB, "lw_mem_wait");
    step(1, 1, 1, 0, DREQ | ALB, "lw_mem_done");
    step(1, 1, 1, 0, RFW | PCEN | RET | WB1 | ALB, "lw_wb");

    // BEQ taken, then not taken
    set_insn(7'b1100011, 3'd0);
    step(1, 1, 1, 0, FET, "beq1_fetch");
    step(1, 1, 1, 0, NONE, "beq1_decode");
    step(1, 1, 1, 1, PCEN | PCS1 | RET | ALA, "beq_taken");
    step(1, 1, 1, 0, FET, "beq2_fetch");
    step(1, 1, 1, 0, NONE, "beq2_decode");
    step(1, 1, 1, 0, PCEN | RET | ALA, "beq_not_taken");

    // SW, zero-wait
    set_insn(7'b0100011, 3'd2);
    step(1, 1, 1, 0, FET, "sw_fetch");
    step(1, 1, 1, 0, NONE, "sw_decode");
    step(1, 1, 1, 0, ALB, "sw_exec");
    step(1, 1, 1, 0, DREQ | DWE | PCEN | RET | ALB, "sw_mem");

    // JALR and JAL
    set_insn(7'b1100111, 3'd0);
    step(1, 1, 1, 0, FET, "jalr_fetch");
    step(1, 1, 1, 0, NONE, "jalr_decode");
    step(1, 1, 1, 0, ALB, "jalr_exec");
    step(1, 1, 1, 0, RFW | PCEN | RET | WB2 | PCS2 | ALB, "jalr_wb");
    set_insn(7'b1101111, 3'd0);
    step(1, 1, 1, 0, FET, "jal_fetch");
    step(1, 1, 1, 0, NONE, "jal_decode");
    step(1, 1, 1, 0, ALA | ALB, "jal_exec");
    step(1, 1, 1, 0, RFW | PCEN | RET | WB2 | PCS1 | ALA | ALB, "jal_wb");

    // Fetch timeout with TIMEOUT=4: five request cycles, then trap
    set_insn(7'b0010011, 3'd0);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, IREQ, "to_fetch_wait");
    step(1, 0, 1, 0, TRP, "to_trap");
    step(1, 1, 1, 0, TRP, "to_trap_sticky");
    step(0, 1, 1, 0, NONE, "to_reset");

    // Ready arrives on the fifth request cycle: accepted, no trap
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, IREQ, "late_fetch_wait");
    step(1, 1, 1, 0, FET, "late_fetch_accept");
    step(1, 1, 1, 0, NONE, "late_decode");
    step(1, 1, 1, 0, ALB, "late_exec");
    step(1, 1, 1, 0, RFW | PCEN | RET | ALB, "late_wb");

    // Illegal opcode
    set_insn(7'b1111111, 3'd0);
    step(1, 1, 1, 0, FET, "ill_fetch");
    step(1, 1, 1, 0, NONE, "ill_decode");
    step(1, 1, 1, 0, TRP, "ill_trap");
    step(1, 1, 1, 0, TRP, "ill_trap_sticky");
    step(0, 1, 1, 0, NONE, "ill_reset");

    // SYSTEM with funct3 != 0 traps
    set_insn(7'b1110011, 3'd1);
    step(1, 1, 1, 0, FET, "sys_fetch");
    step(1, 1, 1, 0, NONE, "sys_decode");
    step(1, 1, 1, 0, TRP, "sys_trap");
    step(0, 1, 1, 0, NONE, "sys_reset");

    // EBREAK halts
    set_insn(7'b1110011, 3'd0);
    step(1, 1, 1, 0, FET, "ebreak_fetch");
    step(1, 1, 1, 0, NONE, "ebreak_decode");
    step(1, 1, 1, 0, HLT, "ebreak_halt");
    step(1, 1, 1, 0, HLT, "ebreak_halt_sticky");
    step(0, 1, 1, 0, NONE, "ebreak_reset");

    // Reset in the middle of a LW memory wait abandons it
    set_insn(7'b0000011, 3'd2);
    step(1, 1, 0, 0, FET, "mid_fetch");
    step(1, 1, 0, 0, NONE, "mid_decode");
    step(1, 1, 0, 0, ALB, "mid_exec");
    step(1, 1, 0, 0, DREQ | ALB, "mid_mem");
    step(0, 1, 1, 0, NONE, "mid_reset");
    set_insn(7'b0010011, 3'd0);
    step(1, 1, 1, 0, FET, "post_fetch");
    step(1, 1, 1, 0, NONE, "post_decode");
    step(1, 1, 1, 0, ALB, "post_exec");
    step(1, 1, 1, 0, RFW | PCEN | RET | ALB, "post_wb");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
